// File: rtl/mm_scheduler_if.sv
// Bus between the instruction decoder / MM engine side and the scheduler.
// The scheduler uses the slave modport; the decoder/engine side uses master.
interface mm_scheduler_if #(
  parameter int FIFO_DEPTH = 4,
  parameter int CYC_W      = 32
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Instruction port
  logic               inst_valid;
  logic               inst_ready;
  logic [127:0]       inst_data;

  // Engine parameter bus and control
  logic [12:0]        weight_start_addr;
  logic [10:0]        input_start_addr;
  logic [10:0]        output_start_addr;
  logic [8:0]         bias_start_addr;
  logic [7:0]         input_addr_per_feature;
  logic [7:0]         output_addr_per_feature;
  logic [15:0]        number_of_node;
  logic               r;
  logic               a;
  logic               b;
  logic               start_valid;
  logic               done;

  // Completion record
  logic               cmpl_valid;
  logic               cmpl_ready;
  logic [7:0]         cmpl_id;
  logic               cmpl_err;
  logic [CYC_W-1:0]   cmpl_cycles;

  // Status
  logic               busy;
  logic [CNT_W-1:0]   fifo_count;
  logic               spurious_done;

  modport slave (
    input  inst_valid, inst_data, done, cmpl_ready,
    output inst_ready, weight_start_addr, input_start_addr, output_start_addr,
           bias_start_addr, input_addr_per_feature, output_addr_per_feature,
           number_of_node, r, a, b, start_valid, cmpl_valid, cmpl_id, cmpl_err,
           cmpl_cycles, busy, fifo_count, spurious_done
  );

  modport master (
    output inst_valid, inst_data, done, cmpl_ready,
    input  inst_ready, weight_start_addr, input_start_addr, output_start_addr,
           bias_start_addr, input_addr_per_feature, output_addr_per_feature,
           number_of_node, r, a, b, start_valid, cmpl_valid, cmpl_id, cmpl_err,
           cmpl_cycles, busy, fifo_count, spurious_done
  );
endinterface

// File: rtl/mm_scheduler.sv
// Instruction-level sequencer for the matrix-multiply engine: buffers packed
// instructions, issues one start pulse per instruction, holds the parameter
// bus until the engine's done pulse and returns a completion record.
module mm_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int CYC_W      = 32
) (
  input  logic          clk,
  input  logic          rstn,
  mm_scheduler_if.slave bus
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int INST_W = 87;  // bits [86:0] carry fields; the rest is reserved

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]        state;
  logic [INST_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [INST_W-1:0] head;
  logic [INST_W-1:0] prm;
  logic [CYC_W-1:0]  cycles;
  logic              err;
  logic              spurious;
  logic              push;
  logic              pop;
  logic              head_zero;
  logic              unused_reserved;

  assign unused_reserved = ^bus.inst_data[127:INST_W];

  assign bus.inst_ready = (count != CNT_W'(FIFO_DEPTH));
  assign push           = bus.inst_valid && bus.inst_ready;
  assign pop            = (state == IDLE) && (count != '0);
  assign head           = mem[rd_ptr];
  // Zero Ci, Co or N means the engine would have nothing to do.
  assign head_zero      = (head[59:52] == '0) || (head[67:60] == '0) || (head[83:68] == '0);

  // Instruction storage write port.
  // NOTE: the storage array is deliberately not reset; validity is tracked by
  // the pointers and count, so resetting every entry would only cost logic.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.inst_data[INST_W-1:0];
  end

  // FIFO pointers and occupancy; simultaneous push and pop cancel out.
  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer: pop, issue, wait for done, present completion.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      prm      <= '0;
      cycles   <= '0;
      err      <= 1'b0;
      spurious <= 1'b0;
    end else begin
      // The engine cannot legally finish outside RUN (including the ISSUE cycle).
      if (bus.done && (state != RUN)) spurious <= 1'b1;
      case (state)
        IDLE: begin
          if (pop) begin
            prm    <= head;
            cycles <= '0;
            err    <= head_zero;
            state  <= head_zero ? RESP : ISSUE;
          end
        end
        ISSUE: begin
          cycles <= CYC_W'(1);
          state  <= RUN;
        end
        RUN: begin
          if (cycles != '1) cycles <= cycles + CYC_W'(1);
          if (bus.done) begin
            err   <= 1'b0;
            state <= RESP;
          end
        end
        default: begin  // RESP
          if (bus.cmpl_ready) state <= IDLE;
        end
      endcase
    end
  end

  // Parameter bus: bit-exact copies of the popped instruction fields.
  assign bus.weight_start_addr       = prm[20:8];
  assign bus.input_start_addr        = prm[31:21];
  assign bus.output_start_addr       = prm[42:32];
  assign bus.bias_start_addr         = prm[51:43];
  assign bus.input_addr_per_feature  = prm[59:52];
  assign bus.output_addr_per_feature = prm[67:60];
  assign bus.number_of_node          = prm[83:68];
  assign bus.r                       = prm[84];
  assign bus.a                       = prm[85];
  assign bus.b                       = prm[86];

  assign bus.start_valid   = (state == ISSUE);
  assign bus.cmpl_valid    = (state == RESP);
  assign bus.cmpl_id       = prm[7:0];
  assign bus.cmpl_err      = err;
  assign bus.cmpl_cycles   = cycles;
  assign bus.busy          = (state != IDLE) || (count != '0);
  assign bus.fifo_count    = count;
  assign bus.spurious_done = spurious;
endmodule

// File: tb/tb_mm_scheduler.sv
// Directed bench for mm_scheduler: a small engine model answers start pulses
// after a per-id latency, completions are captured by a monitor and compared
// in order against a scoreboard of expected records.
module tb_mm_scheduler;
  localparam int FIFO_DEPTH = 4;
  localparam int CYC_W      = 32;

  typedef struct {
    logic [7:0]       id;
    logic             err;
    logic [CYC_W-1:0] cycles;
  } cmpl_rec_t;

  logic clk = 1'b0;
  logic rstn;

  mm_scheduler_if #(.FIFO_DEPTH(FIFO_DEPTH), .CYC_W(CYC_W)) bus ();

  mm_scheduler #(.FIFO_DEPTH(FIFO_DEPTH), .CYC_W(CYC_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int        n_total = 0;
  int        n_pass  = 0;
  int        n_fail  = 0;
  cmpl_rec_t exp_q[$];
  cmpl_rec_t obs_q[$];
  int        obs_idx = 0;
  int        lat_tab [256];
  logic      auto_done = 1'b1;
  logic      man_done  = 1'b0;
  logic      eng_done;
  int        eng_cnt;
  int        start_cnt = 0;

  assign bus.done = eng_done | man_done;

  // Engine model: done pulse lat_tab[id] cycles after the start pulse.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      eng_cnt  <= 0;
      eng_done <= 1'b0;
    end else begin
      eng_done <= 1'b0;
      if (bus.start_valid) begin
        start_cnt <= start_cnt + 1;
        if (auto_done) begin
          if (lat_tab[bus.cmpl_id] <= 1) eng_done <= 1'b1;
          else                           eng_cnt  <= lat_tab[bus.cmpl_id] - 1;
        end
      end else if (eng_cnt > 0) begin
        eng_cnt <= eng_cnt - 1;
        if (eng_cnt == 1) eng_done <= 1'b1;
      end
    end
  end

  // Completion monitor: record every handshaken completion.
  always @(negedge clk) begin
    if (rstn && bus.cmpl_valid && bus.cmpl_ready)
      obs_q.push_back('{id: bus.cmpl_id, err: bus.cmpl_err, cycles: bus.cmpl_cycles});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk(input logic [7:0] id, input logic [12:0] ws,
                                      input logic [10:0] is, input logic [10:0] os,
                                      input logic [8:0] bs, input logic [7:0] ci,
                                      input logic [7:0] co, input logic [15:0] n,
                                      input logic r, input logic a, input logic b);
    logic [127:0] v;
    v          = '1;  // reserved bits all ones: they must be ignored
    v[7:0]     = id;
    v[20:8]    = ws;
    v[31:21]   = is;
    v[42:32]   = os;
    v[51:43]   = bs;
    v[59:52]   = ci;
    v[67:60]   = co;
    v[83:68]   = n;
    v[84]      = r;
    v[85]      = a;
    v[86]      = b;
    return v;
  endfunction

  function automatic logic [86:0] params_vec();
    return {bus.weight_start_addr, bus.input_start_addr, bus.output_start_addr,
            bus.bias_start_addr, bus.input_addr_per_feature, bus.output_addr_per_feature,
            bus.number_of_node, bus.r, bus.a, bus.b, bus.cmpl_id};
  endfunction

  task automatic exp_push(input logic [7:0] id, input logic err, input int cyc);
    exp_q.push_back('{id: id, err: err, cycles: CYC_W'(cyc)});
  endtask

  // Offer one instruction, hold it until accepted; returns cycles spent waiting.
  task automatic push_inst(input logic [127:0] d, output int waited);
    waited         = 0;
    bus.inst_valid = 1'b1;
    bus.inst_data  = d;
    while (!bus.inst_ready && waited < 200) begin
      tick();
      waited++;
    end
    check("push_accept_bound", 64'(waited < 200), 64'(1));
    tick();
    bus.inst_valid = 1'b0;
  endtask

  // Wait for the next captured completion and compare it with the scoreboard head.
  task automatic wait_cmpl(input string tag);
    cmpl_rec_t e;
    cmpl_rec_t o;
    int n = 0;
    while (obs_q.size() <= obs_idx && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_arrived"}, 64'(obs_q.size() > obs_idx), 64'(1));
    if (obs_q.size() > obs_idx) begin
      o = obs_q[obs_idx];
      obs_idx++;
      check({tag, "_expected"}, 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check({tag, "_id"},     64'(o.id),     64'(e.id));
        check({tag, "_err"},    64'(o.err),    64'(e.err));
        check({tag, "_cycles"}, 64'(o.cycles), 64'(e.cycles));
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_inst_ready"},  64'(bus.inst_ready),    64'(1));
    check({tag, "_fifo_count"},  64'(bus.fifo_count),    64'(0));
    check({tag, "_start"},       64'(bus.start_valid),   64'(0));
    check({tag, "_cmpl_valid"},  64'(bus.cmpl_valid),    64'(0));
    check({tag, "_busy"},        64'(bus.busy),          64'(0));
    check({tag, "_spurious"},    64'(bus.spurious_done), 64'(0));
    check({tag, "_params"},      64'(params_vec() != '0), 64'(0));
    check({tag, "_cmpl_err"},    64'(bus.cmpl_err),      64'(0));
    check({tag, "_cmpl_cycles"}, 64'(bus.cmpl_cycles),   64'(0));
  endtask

  initial begin
    logic [86:0] snap;
    logic [40:0] csnap;
    int w;
    int n;
    int unstable;
    int s0;
    int n_obs;

    for (int i = 0; i < 256; i++) lat_tab[i] = 4;
    bus.inst_valid = 1'b0;
    bus.inst_data  = '0;
    bus.cmpl_ready = 1'b1;
    rstn = 1'b0;
    repeat (2) tick();
    check_reset_outputs("rst");
    rstn = 1'b1;
    tick();

    // Single instruction, done 30 cycles after start.
    lat_tab[8'h11] = 30;
    exp_push(8'h11, 1'b0, 31);
    s0 = start_cnt;
    push_inst(mk(8'h11, 13'h100, 11'h2A5, 11'h7FF, 9'h1C3, 8'd2, 8'd3, 16'd4, 1'b1, 1'b0, 1'b1), w);
    check("t1_count_after_push", 64'(bus.fifo_count), 64'(1));
    check("t1_busy", 64'(bus.busy), 64'(1));
    check("t1_no_start_at_pop", 64'(bus.start_valid), 64'(0));
    tick();
    check("t1_start", 64'(bus.start_valid), 64'(1));
    check("t1_weight", 64'(bus.weight_start_addr), 64'(13'h100));
    check("t1_input", 64'(bus.input_start_addr), 64'(11'h2A5));
    check("t1_output", 64'(bus.output_start_addr), 64'(11'h7FF));
    check("t1_bias", 64'(bus.bias_start_addr), 64'(9'h1C3));
    check("t1_ci_co_n", 64'({bus.input_addr_per_feature, bus.output_addr_per_feature, bus.number_of_node}),
          64'({8'd2, 8'd3, 16'd4}));
    check("t1_rab", 64'({bus.r, bus.a, bus.b}), 64'(3'b101));
    snap = params_vec();
    n = 0;
    unstable = 0;
    while (!bus.cmpl_valid && n < 100) begin
      tick();
      n++;
      if (params_vec() !== snap) unstable++;
    end
    check("t1_cmpl_latency", 64'(n), 64'(31));
    check("t1_params_stable", 64'(unstable), 64'(0));
    wait_cmpl("t1");
    check("t1_one_start", 64'(start_cnt - s0), 64'(1));

    // Zero-size rejection: N==0, then Ci==0.
    s0 = start_cnt;
    exp_push(8'h22, 1'b1, 0);
    push_inst(mk(8'h22, 13'h0AA, 11'h011, 11'h022, 9'h033, 8'd2, 8'd3, 16'd0, 1'b0, 1'b1, 1'b0), w);
    tick();
    check("t2_cmpl_after_pop", 64'(bus.cmpl_valid), 64'(1));
    check("t2_err", 64'(bus.cmpl_err), 64'(1));
    wait_cmpl("t2n");
    exp_push(8'h23, 1'b1, 0);
    push_inst(mk(8'h23, 13'h001, 11'h001, 11'h001, 9'h001, 8'd0, 8'd5, 16'd9, 1'b1, 1'b1, 1'b1), w);
    wait_cmpl("t2ci");
    check("t2_no_start", 64'(start_cnt - s0), 64'(0));

    // Completion back-pressure for 10 cycles with a second instruction queued.
    bus.cmpl_ready = 1'b0;
    lat_tab[8'h33] = 5;
    lat_tab[8'h34] = 3;
    exp_push(8'h33, 1'b0, 6);
    exp_push(8'h34, 1'b0, 4);
    push_inst(mk(8'h33, 13'h1234, 11'h100, 11'h200, 9'h100, 8'd1, 8'd1, 16'd1, 1'b0, 1'b0, 1'b0), w);
    push_inst(mk(8'h34, 13'h0FFF, 11'h3FF, 11'h0FF, 9'h0FF, 8'd7, 8'd8, 16'd9, 1'b1, 1'b1, 1'b0), w);
    n = 0;
    while (!bus.cmpl_valid && n < 100) begin
      tick();
      n++;
    end
    csnap = {bus.cmpl_id, bus.cmpl_err, bus.cmpl_cycles};
    s0 = start_cnt;
    unstable = 0;
    repeat (10) begin
      tick();
      if ({bus.cmpl_id, bus.cmpl_err, bus.cmpl_cycles} !== csnap || !bus.cmpl_valid) unstable++;
    end
    check("t3_fields_hold", 64'(unstable), 64'(0));
    check("t3_held_id", 64'(bus.cmpl_id), 64'(8'h33));
    check("t3_held_cycles", 64'(bus.cmpl_cycles), 64'(6));
    check("t3_no_pop", 64'(bus.fifo_count), 64'(1));
    check("t3_no_start", 64'(start_cnt - s0), 64'(0));
    bus.cmpl_ready = 1'b1;
    tick();
    check("t3_no_start_hs1", 64'(bus.start_valid), 64'(0));
    tick();
    check("t3_start_hs2", 64'(bus.start_valid), 64'(1));
    wait_cmpl("t3a");
    wait_cmpl("t3b");

    // Five back-to-back pushes while a long instruction runs.
    lat_tab[8'h40] = 40;
    exp_push(8'h40, 1'b0, 41);
    push_inst(mk(8'h40, 13'h0040, 11'h040, 11'h040, 9'h040, 8'd4, 8'd4, 16'd4, 1'b0, 1'b0, 1'b1), w);
    tick();
    for (int i = 1; i <= 4; i++) begin
      lat_tab[8'h40 + i] = 1 + i;
      exp_push(8'(8'h40 + i), 1'b0, 2 + i);
      push_inst(mk(8'(8'h40 + i), 13'(i * 3), 11'(i * 5), 11'(i * 7), 9'(i * 11),
                   8'(i), 8'(i + 1), 16'(i + 2), i[0], i[1], i[2]), w);
    end
    check("t4_full_count", 64'(bus.fifo_count), 64'(4));
    check("t4_full_not_ready", 64'(bus.inst_ready), 64'(0));
    lat_tab[8'h45] = 6;
    exp_push(8'h45, 1'b0, 7);
    push_inst(mk(8'h45, 13'h1FFF, 11'h7FF, 11'h7FF, 9'h1FF, 8'hFF, 8'hFF, 16'hFFFF, 1'b1, 1'b1, 1'b1), w);
    check("t4_fifth_waited", 64'(w > 0), 64'(1));
    check("t4_first_done_before_fifth", 64'(obs_q.size() > obs_idx), 64'(1));
    check("t4_count_after_fifth", 64'(bus.fifo_count), 64'(4));
    for (int i = 0; i < 6; i++) wait_cmpl("t4");

    // Spurious done in IDLE and on the ISSUE cycle.
    auto_done = 1'b0;
    check("t5_spurious_clear", 64'(bus.spurious_done), 64'(0));
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    tick();
    check("t5_spurious_idle", 64'(bus.spurious_done), 64'(1));
    check("t5_idle_unaffected", 64'(bus.busy), 64'(0));
    exp_push(8'h51, 1'b0, 7);
    push_inst(mk(8'h51, 13'h0051, 11'h051, 11'h051, 9'h051, 8'd5, 8'd1, 16'd3, 1'b1, 1'b0, 1'b0), w);
    tick();
    check("t5_issue", 64'(bus.start_valid), 64'(1));
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    repeat (5) tick();
    check("t5_still_running", 64'({bus.busy, bus.cmpl_valid}), 64'(2'b10));
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    check("t5_cmpl_after_real_done", 64'(bus.cmpl_valid), 64'(1));
    wait_cmpl("t5");
    check("t5_spurious_sticky", 64'(bus.spurious_done), 64'(1));
    auto_done = 1'b1;

    // Reset mid-RUN with two entries queued.
    lat_tab[8'h61] = 50;
    exp_push(8'h61, 1'b0, 51);
    push_inst(mk(8'h61, 13'h0ABC, 11'h123, 11'h456, 9'h0AB, 8'd9, 8'd9, 16'd9, 1'b1, 1'b0, 1'b1), w);
    push_inst(mk(8'h62, 13'h0001, 11'h002, 11'h003, 9'h004, 8'd1, 8'd1, 16'd1, 1'b0, 1'b0, 1'b0), w);
    push_inst(mk(8'h63, 13'h0005, 11'h006, 11'h007, 9'h008, 8'd1, 8'd1, 16'd1, 1'b0, 1'b0, 1'b0), w);
    repeat (3) tick();
    check("t6_queued", 64'(bus.fifo_count), 64'(2));
    rstn = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    exp_q.delete();
    n_obs = obs_q.size();
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    check("t6_no_abandoned_cmpl", 64'(obs_q.size()), 64'(n_obs));
    lat_tab[8'h71] = 4;
    exp_push(8'h71, 1'b0, 5);
    push_inst(mk(8'h71, 13'h0071, 11'h071, 11'h071, 9'h071, 8'd2, 8'd2, 16'd2, 1'b0, 1'b1, 1'b0), w);
    wait_cmpl("t6_after");

    repeat (3) tick();
    check("end_scoreboard_empty", 64'(exp_q.size()), 64'(0));
    check("end_no_extra_cmpl", 64'(obs_q.size() - obs_idx), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
